// File: rtl/defines_package.sv
// Shared types for the texel path: vertex, triangle and colour layouts plus frame markers.
package defines_package;

    localparam logic [31:0] FRAME_START = 32'h0000_0000;
    localparam logic [31:0] FRAME_END   = 32'h0000_0001;
    localparam int          TEXEL_W     = 168;

    typedef struct packed {
        logic [15:0] z;
        logic [15:0] y;
        logic [15:0] x;
    } Point3D;

    typedef struct packed {
        Point3D r;
        Point3D q;
        Point3D p;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } Color;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/texel_assembler.sv
// Assembles one texel (triangle + colour) from a header word and six payload words.
// Latency: texel_ready one cycle after the 7th consuming edge; 7 cycles minimum per frame.
// Backpressure: stops popping AHB words while a texel is held; releases on texel_read.
module texel_assembler
    import defines_package::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic [31:0]       ahb_buffer,
    input  logic              ahb_data_available,
    output logic              ahb_user_read_buffer,
    input  logic              texel_read,
    output Triangle3D         texel_vertices_out,
    output Color              texel_color_out,
    output logic              texel_ready
);

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           count;
    logic [TEXEL_W-1:0]   texel_word;
    logic                 word_vld;

    assign word_vld = ahb_data_available && ahb_user_read_buffer;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (word_vld && (ahb_buffer == FRAME_START)) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (word_vld && (count == 3'd5)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (texel_read) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ahb_user_read_buffer = (state != READY);
        texel_ready          = (state == READY);
    end

    // A header value inside LOAD is ordinary payload: no resync once a frame has started.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count      <= 3'd0;
            texel_word <= '0;
        end else if (word_vld) begin
            if (state == IDLE) begin
                count <= 3'd0;
            end else if (state == LOAD) begin
                count <= (count == 3'd5) ? 3'd0 : count + 3'd1;
                case (count)
                    3'd0:    texel_word[31:0]    <= ahb_buffer;
                    3'd1:    texel_word[63:32]   <= ahb_buffer;
                    3'd2:    texel_word[95:64]   <= ahb_buffer;
                    3'd3:    texel_word[127:96]  <= ahb_buffer;
                    3'd4:    texel_word[159:128] <= ahb_buffer;
                    3'd5:    texel_word[167:160] <= ahb_buffer[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign texel_vertices_out = texel_word[143:0];
    assign texel_color_out    = texel_word[167:144];

endmodule

// File: tb/tb_texel_assembler.sv
// Bench for texel_assembler: directed vector table, hand-written corner sequences,
// then randomized traffic against a word-log reference model.
module tb_texel_assembler
    import defines_package::*;
;

    logic        tb_clk;
    logic        n_rst;
    logic [31:0] ahb_buffer;
    logic        ahb_data_available;
    logic        ahb_user_read_buffer;
    logic        texel_read;
    Triangle3D   texel_vertices_out;
    Color        texel_color_out;
    logic        texel_ready;

    int checks;
    int failures;

    texel_assembler dut (
        .clk                  (tb_clk),
        .n_rst                (n_rst),
        .ahb_buffer           (ahb_buffer),
        .ahb_data_available   (ahb_data_available),
        .ahb_user_read_buffer (ahb_user_read_buffer),
        .texel_read           (texel_read),
        .texel_vertices_out   (texel_vertices_out),
        .texel_color_out      (texel_color_out),
        .texel_ready          (texel_ready)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic        avail;
        logic [31:0] word;
        logic        rd;
        logic        exp_ready;
        logic        exp_rb;
        logic        chk_data;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] frame_w [7];
    Triangle3D   exp_vert;
    Color        exp_col;

    logic [31:0] pending [$];
    logic [31:0] popped [$];

    task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are read at the next falling edge.
    task automatic cyc(input logic a, input logic [31:0] w, input logic r);
        ahb_data_available = a;
        ahb_buffer         = w;
        texel_read         = r;
        @(posedge tb_clk);
        @(negedge tb_clk);
    endtask

    task automatic chk_flags(input string name, input logic rdy, input logic rb);
        chk({name, "_ready"}, 168'(texel_ready), 168'(rdy));
        chk({name, "_rdbuf"}, 168'(ahb_user_read_buffer), 168'(rb));
    endtask

    task automatic chk_ref_texel(input string name);
        chk({name, "_vert"}, 168'(texel_vertices_out), 168'(exp_vert));
        chk({name, "_col"},  168'(texel_color_out),    168'(exp_col));
    endtask

    task automatic send_payload(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            cyc(1'b1, frame_w[k], 1'b0);
        end
    endtask

    // Model: index of the first header word in the log since the last handshake, or -1.
    function automatic int hdr_idx();
        for (int i = 0; i < popped.size(); i++) begin
            if (popped[i] == FRAME_START) return i;
        end
        return -1;
    endfunction

    function automatic logic model_ready();
        int h;
        h = hdr_idx();
        return (h >= 0) && (popped.size() >= h + 7);
    endfunction

    function automatic logic [167:0] model_texel();
        int h;
        h = hdr_idx();
        return {popped[h+6][7:0], popped[h+5], popped[h+4], popped[h+3], popped[h+2], popped[h+1]};
    endfunction

    task automatic refill();
        if ($urandom_range(0, 2) == 0) pending.push_back($urandom | 32'h0000_0100);
        pending.push_back(FRAME_START);
        for (int k = 0; k < 6; k++) pending.push_back($urandom);
        pending.push_back(FRAME_END);
    endtask

    initial begin
        logic a;
        logic r;
        logic m_rdy;

        checks   = 0;
        failures = 0;

        frame_w[0] = 32'h0000_0000;
        frame_w[1] = 32'h3322_1100;
        frame_w[2] = 32'h7766_5544;
        frame_w[3] = 32'hBBAA_9988;
        frame_w[4] = 32'hFFEE_DDCC;
        frame_w[5] = 32'h7654_3210;
        frame_w[6] = 32'hFEDB_CA98;

        exp_vert.p.x = 16'h1100; exp_vert.p.y = 16'h3322; exp_vert.p.z = 16'h5544;
        exp_vert.q.x = 16'h7766; exp_vert.q.y = 16'h9988; exp_vert.q.z = 16'hBBAA;
        exp_vert.r.x = 16'hDDCC; exp_vert.r.y = 16'hFFEE; exp_vert.r.z = 16'h3210;
        exp_col.r = 8'h54; exp_col.g = 8'h76; exp_col.b = 8'h98;

        // Expected flags are those seen after the row's clock edge.
        for (int i = 0; i < 6; i++) vecs[i] = '{1'b1, frame_w[i], 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, frame_w[6], 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 7; i < 12; i++) vecs[i] = '{1'b1, FRAME_END, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, FRAME_END, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, FRAME_END, 1'b0, 1'b0, 1'b1, 1'b0};

        n_rst              = 1'b0;
        ahb_buffer         = 32'h0;
        ahb_data_available = 1'b0;
        texel_read         = 1'b0;
        repeat (3) @(negedge tb_clk);
        n_rst = 1'b1;
        @(negedge tb_clk);
        chk_flags("reset", 1'b0, 1'b1);
        chk("reset_texel", {texel_color_out, texel_vertices_out}, 168'h0);

        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].avail, vecs[i].word, vecs[i].rd);
            chk_flags($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_rb);
            if (vecs[i].chk_data) chk_ref_texel($sformatf("vec%0d", i));
        end

        // Junk before header, then a 3-cycle availability gap mid-frame.
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
        chk_flags("junk", 1'b0, 1'b1);
        send_payload(0, 3);
        repeat (3) cyc(1'b0, FRAME_START, 1'b0);
        chk_flags("stall", 1'b0, 1'b1);
        send_payload(4, 5);
        chk_flags("stall_pre", 1'b0, 1'b1);
        send_payload(6, 6);
        chk_flags("stall_done", 1'b1, 1'b0);
        chk_ref_texel("stall");
        cyc(1'b0, FRAME_END, 1'b1);
        chk_flags("stall_ack", 1'b0, 1'b1);

        // Asynchronous reset after three payload words.
        send_payload(0, 3);
        #2 n_rst = 1'b0;
        #1;
        chk_flags("midrst", 1'b0, 1'b1);
        chk("midrst_texel", {texel_color_out, texel_vertices_out}, 168'h0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        send_payload(0, 5);
        chk_flags("postrst_pre", 1'b0, 1'b1);
        send_payload(6, 6);
        chk_flags("postrst", 1'b1, 1'b0);
        chk_ref_texel("postrst");
        cyc(1'b0, FRAME_END, 1'b1);
        chk_flags("postrst_ack", 1'b0, 1'b1);

        // Randomized traffic: the model tracks the word log since the last handshake.
        popped.delete();
        pending.delete();
        for (int n = 0; n < 3000; n++) begin
            if (pending.size() < 10) refill();
            a = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
            ahb_data_available = a;
            ahb_buffer         = pending[0];
            texel_read         = r;
            m_rdy = model_ready();
            chk_flags("rand", m_rdy, !m_rdy);
            if (m_rdy) chk("rand_texel", {texel_color_out, texel_vertices_out}, model_texel());
            @(posedge tb_clk);
            if (m_rdy && r) popped.delete();
            else if (a && !m_rdy) popped.push_back(pending.pop_front());
            @(negedge tb_clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/texel_assembler.md
# texel_assembler

Collects one texel (a 3D triangle plus an RGB colour) from a stream of 32-bit words delivered by the AHB slave's user read buffer. It presents the texel as typed structs to the downstream rasteriser stage. Each frame is one FRAME_START header word followed by six payload words. The block pops words with a read strobe, holds the completed texel until the consumer acknowledges it, then re-arms.

## Interface
Parameters: none. FRAME_START = 32'h0000_0000 and FRAME_END = 32'h0000_0001 are package constants.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock, rising edge.
  - n_rst  in  1  asynchronous active-low reset.
- AHB side:
  - ahb_buffer  in  32  head word of the AHB user read buffer.
  - ahb_data_available  in  1  ahb_buffer holds a valid word.
  - ahb_user_read_buffer  out  1  block accepts/pops the head word this cycle.
- Consumer side:
  - texel_read  in  1  consumer acknowledges the presented texel.
  - texel_vertices_out  out  Triangle3D  assembled vertices p,q,r with x,y,z of 16 bits each (144 bits).
  - texel_color_out  out  Color  assembled colour r,g,b of 8 bits each (24 bits).
  - texel_ready  out  1  outputs hold a complete texel.

## Operation
- Internal 168-bit assembly register (texel word). The outputs are continuous slices of it:
  - p.x[15:0], p.y[31:16], p.z[47:32]
  - q.x[63:48], q.y[79:64], q.z[95:80]
  - r.x[111:96], r.y[127:112], r.z[143:128]
  - color.r[151:144], color.g[159:152], color.b[167:160]
- Payload word k (k = 1..6) is written to bits [32k-1 : 32(k-1)].
  - Word 6: only bits [7:0] are kept, into [167:160]; bits [31:8] are discarded.
  - Fields are raw bit copies with no sign or scale processing.
- A word is consumed only when ahb_data_available && ahb_user_read_buffer. Otherwise the state and register are unchanged.
- FSM states:
  - IDLE (reset state):
    - A consumed word equal to FRAME_START goes to LOAD with the word count set to 0.
    - Any other consumed word, including FRAME_END, is discarded and the FSM stays in IDLE.
  - LOAD:
    - Each consumed word is stored at slot = count, and count increments.
    - Storing the 6th word (count == 5) goes to READY.
    - A FRAME_START value seen in LOAD is payload; there is no resync.
  - READY:
    - Holds the assembled texel.
    - texel_read high at a rising edge goes to IDLE.
    - AHB data is not consumed in this state.
- ahb_user_read_buffer = (state != READY). It is combinational from state and asserted regardless of ahb_data_available.
- texel_ready = (state == READY).
- texel_read outside READY is ignored.
- Output contents are defined only while texel_ready = 1. They may change during the next LOAD.
- FRAME_END is not checked. The trailing FRAME_END word is left in the AHB buffer and is discarded by IDLE after the texel is read.

## Timing
- Reset (asynchronous, any state):
  - state = IDLE, count = 0, texel word = 0.
  - texel_ready = 0, ahb_user_read_buffer = 1.
  - All output fields = 0.
- With back-to-back available words, the header plus six payload words take 7 consecutive cycles.
  - texel_ready rises right after the 7th consuming edge.
  - ahb_user_read_buffer falls in the same cycle.
- texel_ready stays high indefinitely until texel_read is sampled high.
  - One cycle after that edge: texel_ready = 0, ahb_user_read_buffer = 1.
- texel_read and ahb_data_available together in READY: no word is consumed; the FSM goes to IDLE.
- Gaps in ahb_data_available stall the FSM in place without losing the count.
- Reset mid-LOAD abandons the partial texel.

## Structure
- The shared package (defines_package) holds:
  - Point3D: packed x,y,z, 16 bits each.
  - Triangle3D: packed p,q,r of Point3D.
  - Color: packed r,g,b, 8 bits each.
  - FRAME_START and FRAME_END.
- Single module: FSM, 3-bit word counter and 168-bit assembly register. No sub-module.

## Test plan
- Reset: after n_rst is released -> texel_ready = 0, ahb_user_read_buffer = 1, outputs = 0.
- Full frame, data_available held high. Stream: 0, 33221100, 77665544, BBAA9988, FFEEDDCC, 76543210, FEDBCA98, 1.
  - read_buffer = 1 and ready = 0 through the first 7 words; after the 7th edge ready = 1 and read_buffer = 0.
  - Vertices: p = (1100, 3322, 5544), q = (7766, 9988, BBAA), r = (DDCC, FFEE, 3210).
  - Colour: (54, 76, 98).
- Hold: 5 idle cycles in READY with FRAME_END still presented -> flags and outputs unchanged; word not popped.
- Handshake: one-cycle texel_read pulse -> next cycle ready = 0, read_buffer = 1. Then FRAME_END is consumed and discarded; the FSM stays in IDLE.
- Resync and stall:
  - Junk word 0xDEADBEEF before FRAME_START -> discarded.
  - data_available dropped for 3 cycles mid-LOAD -> same texel as above.
- Reset after 3 payload words -> IDLE; a following full frame assembles correctly.
